// File: rtl/mem_pkg.sv
// Shared types and helpers for the wait-state memory.
// Provides the FSM state type, the wait-state limit and the counter width.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ACK
  } state_t;

  localparam int WAIT_MAX = 15;

  // Width of a down-counter that must hold values 0..w; never below 1 bit.
  function automatic int cnt_width(input int w);
    int cw;
    cw = $clog2(w + 1);
    return (cw < 1) ? 1 : cw;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM with per-byte write lanes, no reset.
// Ports: clk, en (access strobe), we, addr, be, wdata, rdata (updated on reads only).
module mem_array
  import mem_pkg::*;
#(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
) (
  input  logic                clk,
  input  logic                en,
  input  logic                we,
  input  logic [AWIDTH-1:0]   addr,
  input  logic [DWIDTH/8-1:0] be,
  input  logic [DWIDTH-1:0]   wdata,
  output logic [DWIDTH-1:0]   rdata
);

  localparam int DEPTH = 2 ** AWIDTH;
  localparam int LANES = DWIDTH / 8;

  logic [DWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < LANES; i++) begin
          if (be[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/wait_memory.sv
// Single-port memory with valid/ready requests, WAIT wait states and byte enables.
// Ports: clk, rst_n, req/we/addr/wdata/be (request), clr_drop; ready, ack, rdata, drop.
module wait_memory
  import mem_pkg::*;
#(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8,
  parameter int WAIT   = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  input  logic                we,
  input  logic [AWIDTH-1:0]   addr,
  input  logic [DWIDTH-1:0]   wdata,
  input  logic [DWIDTH/8-1:0] be,
  input  logic                clr_drop,
  output logic                ready,
  output logic                ack,
  output logic [DWIDTH-1:0]   rdata,
  output logic                drop
);

  if (WAIT < 0 || WAIT > WAIT_MAX) begin : g_bad_wait
    $error("wait_memory: WAIT must be in 0..15");
  end

  if (DWIDTH % 8 != 0 || DWIDTH < 8) begin : g_bad_dw
    $error("wait_memory: DWIDTH must be a nonzero multiple of 8");
  end

  localparam int CW = cnt_width(WAIT);
  localparam logic [CW-1:0] CNT_INIT = CW'(WAIT);

  state_t              state;
  logic [CW-1:0]       cnt;
  logic                r_we;
  logic [AWIDTH-1:0]   r_addr;
  logic [DWIDTH-1:0]   r_wdata;
  logic [DWIDTH/8-1:0] r_be;
  logic                rd_seen;
  logic                acc;
  logic [DWIDTH-1:0]   arr_q;

  // The array is touched only on the last BUSY cycle, from the latched copy.
  assign acc = (state == BUSY) && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      ready   <= 1'b1;
      ack     <= 1'b0;
      rd_seen <= 1'b0;
    end else begin
      unique case (state)
        IDLE, ACK: begin
          if (req) begin
            state   <= BUSY;
            cnt     <= CNT_INIT;
            r_we    <= we;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_be    <= be;
            ready   <= 1'b0;
            ack     <= 1'b0;
          end else begin
            state   <= IDLE;
            ready   <= 1'b1;
            ack     <= 1'b0;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt     <= cnt - CW'(1);
          end else begin
            state   <= ACK;
            ready   <= 1'b1;
            ack     <= 1'b1;
            if (!r_we) begin
              rd_seen <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          ack   <= 1'b0;
        end
      endcase
    end
  end

  // A request while busy is discarded; setting beats clearing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop <= 1'b0;
    end else if (req && !ready) begin
      drop <= 1'b1;
    end else if (clr_drop) begin
      drop <= 1'b0;
    end
  end

  mem_array #(
    .AWIDTH (AWIDTH),
    .DWIDTH (DWIDTH)
  ) u_array (
    .clk   (clk),
    .en    (acc),
    .we    (r_we),
    .addr  (r_addr),
    .be    (r_be),
    .wdata (r_wdata),
    .rdata (arr_q)
  );

  // The array output has no reset; mask it until the first read completes.
  assign rdata = rd_seen ? arr_q : '0;

endmodule

// File: tb/tb_wait_memory.sv
// Scoreboard bench: five wait_memory instances with different WAIT/DWIDTH.
// Driver pushes expected acks into per-instance queues; monitors pop on ack.
module tb_wait_memory;

  localparam int NI = 5;
  localparam int WAITS[NI] = '{0, 1, 2, 3, 5};
  localparam int DWS[NI]   = '{16, 8, 16, 16, 16};

  typedef struct {
    int          due;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n    [NI];
  logic        req      [NI];
  logic        we       [NI];
  logic        clr_drop [NI];
  logic [4:0]  addr     [NI];
  logic [15:0] wdata    [NI];
  logic [1:0]  be       [NI];
  logic        ready    [NI];
  logic        ack      [NI];
  logic        drop     [NI];
  logic [15:0] rdata    [NI];

  exp_t        q       [NI][$];
  logic [15:0] mdl     [NI][32];
  bit          wr      [NI][32];
  logic [15:0] last_rd [NI];
  bit          mon_en  [NI];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int k,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] @cyc %0d: got %h expected %h",
               nm, k, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] dmask(input int k);
    return (DWS[k] == 8) ? 16'h00ff : 16'hffff;
  endfunction

  for (genvar k = 0; k < NI; k++) begin : g
    localparam int DW = DWS[k];
    logic [DW-1:0] rd;

    wait_memory #(
      .AWIDTH (5),
      .DWIDTH (DW),
      .WAIT   (WAITS[k])
    ) dut (
      .clk      (clk),
      .rst_n    (rst_n[k]),
      .req      (req[k]),
      .we       (we[k]),
      .addr     (addr[k]),
      .wdata    (wdata[k][DW-1:0]),
      .be       (be[k][DW/8-1:0]),
      .clr_drop (clr_drop[k]),
      .ready    (ready[k]),
      .ack      (ack[k]),
      .rdata    (rd),
      .drop     (drop[k])
    );

    assign rdata[k] = 16'(rd);

    always @(negedge clk) begin : mon
      exp_t e;
      bit   bsy;
      if (rst_n[k] && mon_en[k]) begin
        bsy = (q[k].size() > 0) && (q[k][0].due > cyc);
        chk("ready", k, 32'(ready[k]), 32'(!bsy));
        if (q[k].size() == 0) begin
          chk("spurious_ack", k, 32'(ack[k]), 0);
        end else if (ack[k] === 1'b1) begin
          e = q[k].pop_front();
          chk("ack_cycle", k, cyc, e.due);
          chk("rdata", k, 32'(rdata[k]), 32'(e.data));
        end else if (q[k][0].due < cyc) begin
          e = q[k].pop_front();
          chk("ack_missing", k, cyc, e.due);
        end
      end
    end
  end

  // Present one request; returns at the negedge after the accept edge.
  task automatic issue(input int k, input bit w, input int a,
                       input logic [15:0] d, input logic [1:0] b,
                       input bit commit, output int n);
    int   g;
    exp_t e;
    g = 0;
    n = -1;
    req[k] = 1'b1;
    we[k] = w;
    addr[k] = a[4:0];
    wdata[k] = d;
    be[k] = b;
    while (ready[k] !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("ready_wait", k, 32'(g >= 100), 0);
    if (g >= 100) begin
      req[k] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    n = cyc;
    if (commit) begin
      e.due = n + WAITS[k] + 1;
      if (w) begin
        for (int i = 0; i < DWS[k] / 8; i++)
          if (b[i]) mdl[k][a][8*i +: 8] = d[8*i +: 8];
        if (b == 2'b11 || (DWS[k] == 8 && b[0])) wr[k][a] = 1'b1;
        e.data = last_rd[k];
      end else begin
        last_rd[k] = mdl[k][a] & dmask(k);
        e.data = last_rd[k];
      end
      q[k].push_back(e);
    end
    @(negedge clk);
    req[k] = 1'b0;
    chk("ready_after_accept", k, 32'(ready[k]), 0);
  endtask

  task automatic drain(input int k);
    int g;
    g = 0;
    while (q[k].size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("drain", k, q[k].size(), 0);
  endtask

  task automatic t_extreme_and_be();
    int n;
    issue(0, 1, 0, 16'hffff, 2'b11, 1, n);
    issue(0, 1, 31, 16'h0000, 2'b11, 1, n);
    issue(0, 0, 0, 16'h0, 2'b00, 1, n);
    issue(0, 0, 31, 16'h0, 2'b00, 1, n);
    issue(0, 1, 9, 16'h1234, 2'b11, 1, n);
    issue(0, 1, 9, 16'habcd, 2'b01, 1, n);
    issue(0, 0, 9, 16'h0, 2'b00, 1, n);
    issue(0, 1, 9, 16'h7777, 2'b00, 1, n);
    issue(0, 0, 9, 16'h0, 2'b00, 1, n);
    drain(0);
    chk("be_final", 0, 32'(mdl[0][9]), 32'h12cd);
  endtask

  task automatic t_sweep();
    int n;
    int prev;
    prev = 0;
    for (int i = 0; i < 31; i++) begin
      issue(1, 1, 31 - i, 16'(i), 2'b01, 1, n);
      if (i > 0) chk("sweep_spacing", 1, n - prev, 3);
      prev = n;
    end
    for (int i = 0; i < 31; i++) issue(1, 0, 31 - i, 16'h0, 2'b00, 1, n);
    drain(1);
  endtask

  task automatic t_drop();
    int n;
    chk("drop_init", 2, 32'(drop[2]), 0);
    issue(2, 1, 12, 16'h1357, 2'b11, 1, n);
    req[2] = 1'b1;
    we[2] = 1'b1;
    addr[2] = 5'd12;
    wdata[2] = 16'hdead;
    be[2] = 2'b11;
    @(negedge clk);
    req[2] = 1'b0;
    chk("drop_set", 2, 32'(drop[2]), 1);
    issue(2, 0, 12, 16'h0, 2'b00, 1, n);
    req[2] = 1'b1;
    clr_drop[2] = 1'b1;
    wdata[2] = 16'hbeef;
    @(negedge clk);
    req[2] = 1'b0;
    clr_drop[2] = 1'b0;
    chk("drop_set_wins", 2, 32'(drop[2]), 1);
    drain(2);
    clr_drop[2] = 1'b1;
    @(negedge clk);
    clr_drop[2] = 1'b0;
    chk("drop_clear", 2, 32'(drop[2]), 0);
    issue(2, 0, 12, 16'h0, 2'b00, 1, n);
    drain(2);
  endtask

  task automatic t_wait3();
    int n;
    issue(3, 1, 7, 16'ha55a, 2'b11, 1, n);
    issue(3, 0, 7, 16'h0, 2'b00, 1, n);
    drain(3);
  endtask

  task automatic t_reset();
    int n;
    int seen;
    issue(4, 1, 4, 16'h00c3, 2'b11, 1, n);
    drain(4);
    mon_en[4] = 1'b0;
    issue(4, 1, 4, 16'h005a, 2'b11, 0, n);
    req[4] = 1'b1;
    addr[4] = 5'd9;
    @(posedge clk);
    #1;
    req[4] = 1'b0;
    chk("rst_pre_drop", 4, 32'(drop[4]), 1);
    @(posedge clk);
    #2;
    rst_n[4] = 1'b0;
    #1;
    chk("rst_ready", 4, 32'(ready[4]), 1);
    chk("rst_ack", 4, 32'(ack[4]), 0);
    chk("rst_rdata", 4, 32'(rdata[4]), 0);
    chk("rst_drop", 4, 32'(drop[4]), 0);
    last_rd[4] = 16'h0;
    repeat (2) @(negedge clk);
    rst_n[4] = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack[4] === 1'b1) seen++;
    end
    chk("rst_no_ack", 4, seen, 0);
    mon_en[4] = 1'b1;
    issue(4, 0, 4, 16'h0, 2'b00, 1, n);
    drain(4);
  endtask

  task automatic rand_run(input int k);
    int   n;
    bit   w;
    int   a;
    logic [15:0] d;
    logic [1:0]  b;
    for (int t = 0; t < 40; t++) begin
      w = 1'($urandom_range(0, 1));
      a = $urandom_range(0, 31);
      d = 16'($urandom);
      b = 2'($urandom_range(0, 3));
      if (!w && !wr[k][a]) w = 1'b1;
      issue(k, w, a, d, b, 1, n);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain(k);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst_n[k] = 1'b0;
      req[k] = 1'b0;
      we[k] = 1'b0;
      clr_drop[k] = 1'b0;
      addr[k] = '0;
      wdata[k] = '0;
      be[k] = '0;
      last_rd[k] = 16'h0;
      mon_en[k] = 1'b0;
      for (int a = 0; a < 32; a++) wr[k][a] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("reset_ready", k, 32'(ready[k]), 1);
      chk("reset_ack", k, 32'(ack[k]), 0);
      chk("reset_rdata", k, 32'(rdata[k]), 0);
      chk("reset_drop", k, 32'(drop[k]), 0);
      rst_n[k] = 1'b1;
      mon_en[k] = 1'b1;
    end
    @(negedge clk);
    fork
      t_extreme_and_be();
      t_sweep();
      t_drop();
      t_wait3();
      t_reset();
    join
    fork
      rand_run(0);
      rand_run(1);
      rand_run(2);
      rand_run(3);
      rand_run(4);
    join
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
